// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
interface hazard_ctrl_if;
    logic [4:0] IF_ID_RSaddr_i;
    logic [4:0] IF_ID_RTaddr_i;
    logic       ID_EX_MemRead_i;
    logic [4:0] ID_EX_RTaddr_i;
    logic       EX_MEM_Branch_i;
    logic       EX_MEM_zero_i;
    logic       EX_MEM_MemRead_i;
    logic       EX_MEM_MemWrite_i;
    logic       dmem_ready_i;
    logic       PCWrite_o;
    logic       IF_ID_write_o;
    logic       PCSrc_o;
    logic       IF_ID_flush_o;
    logic       ID_EX_flush_o;
    logic       EX_MEM_flush_o;
    logic       EX_MEM_hold_o;
    logic       ID_EX_hold_o;
    logic       MEM_WB_bubble_o;

    modport master (
        output IF_ID_RSaddr_i, IF_ID_RTaddr_i, ID_EX_MemRead_i, ID_EX_RTaddr_i,
               EX_MEM_Branch_i, EX_MEM_zero_i, EX_MEM_MemRead_i, EX_MEM_MemWrite_i,
               dmem_ready_i,
        input  PCWrite_o, IF_ID_write_o, PCSrc_o, IF_ID_flush_o, ID_EX_flush_o,
               EX_MEM_flush_o, EX_MEM_hold_o, ID_EX_hold_o, MEM_WB_bubble_o
    );

    modport slave (
        input  IF_ID_RSaddr_i, IF_ID_RTaddr_i, ID_EX_MemRead_i, ID_EX_RTaddr_i,
               EX_MEM_Branch_i, EX_MEM_zero_i, EX_MEM_MemRead_i, EX_MEM_MemWrite_i,
               dmem_ready_i,
        output PCWrite_o, IF_ID_write_o, PCSrc_o, IF_ID_flush_o, ID_EX_flush_o,
               EX_MEM_flush_o, EX_MEM_hold_o, ID_EX_hold_o, MEM_WB_bubble_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: memory stall, branch flush, load-use stall
// Optional stall counter output enabled by macro HAZARD_STALL_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    hazard_ctrl_if.slave hz,
`ifdef HAZARD_STALL_CNT_EN
    output logic [15:0] stall_cnt_o,
`endif
    output logic        timeout_o
);

    typedef enum logic {RUN, MEM_WAIT} state_e;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    logic mem_busy, br_taken, load_use;
    logic pc_write, if_id_write, pc_src;
    logic if_id_flush, id_ex_flush, ex_mem_flush;
    logic ex_mem_hold, id_ex_hold, mem_wb_bubble;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        mem_busy = (hz.EX_MEM_MemRead_i | hz.EX_MEM_MemWrite_i) & ~hz.dmem_ready_i;
        br_taken = hz.EX_MEM_Branch_i & hz.EX_MEM_zero_i;
        load_use = hz.ID_EX_MemRead_i & (hz.ID_EX_RTaddr_i != 5'd0) &
                   ((hz.ID_EX_RTaddr_i == hz.IF_ID_RSaddr_i) |
                    (hz.ID_EX_RTaddr_i == hz.IF_ID_RTaddr_i));

        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            RUN: begin
                wait_cnt_d = 8'd0;
                if (mem_busy) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (hz.dmem_ready_i) begin
                    state_d = RUN;
                end else begin
                    if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
                    // Timeout only flags the condition; the FSM keeps waiting.
                    if (wait_cnt_d == TIMEOUT_CNT) timeout_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        pc_src        = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        ex_mem_hold   = 1'b0;
        id_ex_hold    = 1'b0;
        mem_wb_bubble = 1'b0;
        if (rst_i) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (mem_busy) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            ex_mem_hold   = 1'b1;
            id_ex_hold    = 1'b1;
            mem_wb_bubble = 1'b1;
        end else if (br_taken) begin
            pc_src       = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    assign hz.PCWrite_o       = pc_write;
    assign hz.IF_ID_write_o   = if_id_write;
    assign hz.PCSrc_o         = pc_src;
    assign hz.IF_ID_flush_o   = if_id_flush;
    assign hz.ID_EX_flush_o   = id_ex_flush;
    assign hz.EX_MEM_flush_o  = ex_mem_flush;
    assign hz.EX_MEM_hold_o   = ex_mem_hold;
    assign hz.ID_EX_hold_o    = id_ex_hold;
    assign hz.MEM_WB_bubble_o = mem_wb_bubble;
    assign timeout_o          = timeout_q;

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!rst_i && !pc_write && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) stall_cnt_q <= 16'd0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a behavioural model
module tb_hazard_ctrl;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic timeout;
`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    hazard_ctrl_if hif();

    hazard_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .hz(hif),
`ifdef HAZARD_STALL_CNT_EN
        .stall_cnt_o(stall_cnt),
`endif
        .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: waiting on data memory, cycles waited, sticky timeout, stall cycles.
    bit m_waiting = 0;
    int m_wait    = 0;
    bit m_to      = 0;
    int m_stall   = 0;

    // {PCWrite, IF_ID_write, PCSrc, IF_flush, ID_flush, EX_flush, EX_hold, ID_hold, bubble}
    function automatic logic [8:0] model_ctrl();
        bit busy, br, lu;
        busy = (hif.EX_MEM_MemRead_i || hif.EX_MEM_MemWrite_i) && !hif.dmem_ready_i;
        br   = hif.EX_MEM_Branch_i && hif.EX_MEM_zero_i;
        lu   = hif.ID_EX_MemRead_i && hif.ID_EX_RTaddr_i != 0 &&
               (hif.ID_EX_RTaddr_i == hif.IF_ID_RSaddr_i || hif.ID_EX_RTaddr_i == hif.IF_ID_RTaddr_i);
        if (rst)  return 9'b00_0111_000;
        if (busy) return 9'b00_0000_111;
        if (br)   return 9'b11_1111_000;
        if (lu)   return 9'b00_0010_000;
        return 9'b11_0000_000;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic exmr,
                       input logic [4:0] exrt, input logic br, input logic z,
                       input logic mr, input logic mw, input logic rdy, input logic r,
                       input string tag);
        logic [8:0] e, o;
        bit busy;
        @(negedge clk);
        hif.IF_ID_RSaddr_i    = rs;
        hif.IF_ID_RTaddr_i    = rt;
        hif.ID_EX_MemRead_i   = exmr;
        hif.ID_EX_RTaddr_i    = exrt;
        hif.EX_MEM_Branch_i   = br;
        hif.EX_MEM_zero_i     = z;
        hif.EX_MEM_MemRead_i  = mr;
        hif.EX_MEM_MemWrite_i = mw;
        hif.dmem_ready_i      = rdy;
        rst                   = r;
        #1;
        e = model_ctrl();
        o = {hif.PCWrite_o, hif.IF_ID_write_o, hif.PCSrc_o, hif.IF_ID_flush_o, hif.ID_EX_flush_o,
             hif.EX_MEM_flush_o, hif.EX_MEM_hold_o, hif.ID_EX_hold_o, hif.MEM_WB_bubble_o};
        check({tag, "_ctrl"}, {7'd0, o}, {7'd0, e});
        busy = (mr || mw) && !rdy;
        @(posedge clk);
        if (r) begin
            m_waiting = 0; m_wait = 0; m_to = 0; m_stall = 0;
        end else begin
            if (!e[8] && m_stall < 65535) m_stall++;
            if (!m_waiting) begin
                m_wait = 0;
                if (busy) m_waiting = 1;
            end else if (rdy) begin
                m_waiting = 0;
            end else begin
                if (m_wait < 255) m_wait++;
                if (m_wait == TMO) m_to = 1;
            end
        end
        #1;
        check({tag, "_timeout"}, {15'd0, timeout}, {15'd0, m_to});
`ifdef HAZARD_STALL_CNT_EN
        check({tag, "_stallcnt"}, stall_cnt, m_stall[15:0]);
`endif
    endtask

    initial begin
        // Reset held two cycles
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "reset0");
        cyc(3, 4, 1, 3, 1, 1, 1, 0, 0, 1, "reset1");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "idle");

        // Load-use on RS, then on RT, then x0 never stalls
        cyc(5, 7, 1, 5, 0, 0, 0, 0, 1, 0, "lu_rs");
        cyc(1, 2, 0, 5, 0, 0, 0, 0, 1, 0, "lu_after");
        cyc(6, 9, 1, 9, 0, 0, 0, 0, 1, 0, "lu_rt");
        cyc(0, 4, 1, 0, 0, 0, 0, 0, 1, 0, "lu_x0");
        cyc(8, 8, 0, 8, 0, 0, 0, 0, 1, 0, "no_memread");

        // Branch taken beats load-use; branch not taken lets load-use act
        cyc(5, 7, 1, 5, 1, 1, 0, 0, 1, 0, "br_over_lu");
        cyc(5, 7, 1, 5, 1, 0, 0, 0, 1, 0, "br_not_taken");

        // 3-cycle memory stall then release, with load-use in the release cycle
        cyc(1, 2, 0, 0, 1, 1, 1, 0, 0, 0, "mem1");
        cyc(1, 2, 0, 0, 1, 1, 1, 0, 0, 0, "mem2");
        cyc(1, 2, 0, 0, 0, 0, 1, 0, 0, 0, "mem3");
        cyc(3, 2, 1, 3, 0, 0, 1, 0, 1, 0, "mem_release_lu");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, "store_ready");

        // Timeout: held not-ready well past MEM_TIMEOUT, sticky after ready returns
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "tmo_wait");
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, "tmo_release");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "tmo_sticky");
        check("tmo_set", {15'd0, timeout}, 16'd1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "tmo_reset");
        check("tmo_clear", {15'd0, timeout}, 16'd0);

        // Reset during MEM_WAIT must clear the wait counter: a fresh wait needs the full count
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "rw_enter");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "rw_wait1");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "rw_wait2");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, "rw_reset");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rw_run");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "rw_again");
        check("rw_no_early_tmo", {15'd0, timeout}, 16'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "rw_tmo");
        check("rw_tmo_set", {15'd0, timeout}, 16'd1);

`ifdef HAZARD_STALL_CNT_EN
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, "sc_reset");
        cyc(4, 1, 1, 4, 0, 0, 0, 0, 1, 0, "sc_lu1");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "sc_gap");
        cyc(2, 6, 1, 6, 0, 0, 0, 0, 1, 0, "sc_lu2");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, "sc_mem");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, "sc_release");
        check("sc_total", stall_cnt, 16'd5);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cyc(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 16, maximum data-memory wait cycles before timeout_o asserts (range 1..255).
REQ-002 clk_i  in  1  clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  reset, synchronous and active-high.
REQ-004 IF_ID_RSaddr_i, IF_ID_RTaddr_i  in  5 each  source register addresses of the instruction in ID.
REQ-005 ID_EX_MemRead_i  in  1, ID_EX_RTaddr_i  in  5  load flag and destination of the instruction in EX.
REQ-006 EX_MEM_Branch_i, EX_MEM_zero_i  in  1 each  branch flag and ALU zero of the instruction in MEM.
REQ-007 EX_MEM_MemRead_i, EX_MEM_MemWrite_i  in  1 each  data-memory access of the instruction in MEM.
REQ-008 dmem_ready_i  in  1  data memory completes the current access this cycle.
REQ-009 PCWrite_o, IF_ID_write_o  out  1 each  PC / IF_ID load enables.
REQ-010 PCSrc_o  out  1  select branch target for PC.
REQ-011 IF_ID_flush_o, ID_EX_flush_o, EX_MEM_flush_o  out  1 each  zero the control fields of that register at next edge.
REQ-012 EX_MEM_hold_o, ID_EX_hold_o  out  1 each  keep contents of that register at next edge.
REQ-013 MEM_WB_bubble_o  out  1  load MEM_WB with RegWrite=0, MemtoReg=0.
REQ-014 timeout_o  out  1  sticky memory-timeout flag.

Function
REQ-015 FSM states RUN and MEM_WAIT; all outputs except timeout_o are combinational from state and inputs (zero-cycle latency).
REQ-016 mem_busy = (EX_MEM_MemRead_i | EX_MEM_MemWrite_i) & ~dmem_ready_i.
REQ-017 Priority, highest first: mem_busy, branch taken (EX_MEM_Branch_i & EX_MEM_zero_i), load-use; a lower-priority event present in the same cycle is not acted on that cycle.
REQ-018 mem_busy (either state): PCWrite_o=0, IF_ID_write_o=0, ID_EX_hold_o=1, EX_MEM_hold_o=1, MEM_WB_bubble_o=1, all flushes 0, PCSrc_o=0.
REQ-019 RUN->MEM_WAIT on mem_busy; MEM_WAIT->RUN in the cycle dmem_ready_i=1 (stall released that same cycle); otherwise stay.
REQ-020 Branch taken, no mem_busy: PCSrc_o=1, PCWrite_o=1, IF_ID_flush_o=ID_EX_flush_o=EX_MEM_flush_o=1 for exactly that cycle.
REQ-021 Load-use = ID_EX_MemRead_i & (ID_EX_RTaddr_i!=0) & (ID_EX_RTaddr_i==IF_ID_RSaddr_i | ID_EX_RTaddr_i==IF_ID_RTaddr_i); when acted on: PCWrite_o=0, IF_ID_write_o=0, ID_EX_flush_o=1, one cycle per occurrence.
REQ-022 No event: PCWrite_o=1, IF_ID_write_o=1, all flush/hold/bubble/PCSrc 0.
REQ-023 8-bit wait counter clears in RUN, increments each MEM_WAIT cycle with dmem_ready_i=0, saturates at 255.
REQ-024 timeout_o sets at the edge where the counter reaches MEM_TIMEOUT, stays 1 until reset; FSM keeps waiting (no forced release).
REQ-025 A load-use hazard reached after a memory stall is detected normally in the release cycle of the stall.

Reset
REQ-026 rst_i=1 at an edge: state=RUN, wait counter=0, timeout_o=0, stall counter=0, regardless of current state.
REQ-027 While rst_i=1: PCWrite_o=0, IF_ID_write_o=0, all three flush outputs=1, holds/bubble/PCSrc_o=0.

Configuration
REQ-028 Macro HAZARD_STALL_CNT_EN defined: extra output stall_cnt_o (16 bits), incremented once per cycle in which PCWrite_o=0 and rst_i=0, saturating at 16'hFFFF, reset to 0.
REQ-029 Macro undefined: stall_cnt_o port and its counter are absent; all other behaviour identical.

Verification
REQ-030 ID_EX_MemRead_i=1, ID_EX_RTaddr_i=5, IF_ID_RSaddr_i=5 -> one cycle PCWrite_o=0, IF_ID_write_o=0, ID_EX_flush_o=1; ID_EX_RTaddr_i=0 with RS=0 -> no stall.
REQ-031 EX_MEM_Branch_i=1, EX_MEM_zero_i=1, same-cycle load-use -> PCSrc_o=1 and three flushes 1 for one cycle, load-use ignored.
REQ-032 EX_MEM_MemRead_i=1, dmem_ready_i=0 for 3 cycles then 1 -> holds/bubble for 3 cycles, state MEM_WAIT cycles 2-3, release and RUN in 4th.
REQ-033 MEM_TIMEOUT=4, dmem_ready_i held 0 -> timeout_o=1 after 4 MEM_WAIT cycles, stays 1 after ready returns, clears only on rst_i.
REQ-034 rst_i asserted during MEM_WAIT -> next cycle state RUN, counter 0, outputs at reset values while rst_i=1.
REQ-035 With HAZARD_STALL_CNT_EN: 2 load-use stalls plus 3-cycle memory stall -> stall_cnt_o=5.
